// File: rtl/dt_tx_framer_if.sv
// ---------------------------------------------------------------------------
// dt_tx_framer_if
//   CPU/STM-side bus of the DT transmit framer.
//   master : block writer (drives wr_*/commit, sees status/pulses)
//   slave  : framer (samples wr_*/commit, drives fill_busy/tx_int/underrun)
//   wr_en/wr_addr/wr_data : byte write into the fill buffer
//   commit                : one-cycle pulse, hands the fill buffer to the framer
//   fill_busy             : fill buffer committed, waiting for a block swap
//   tx_int / underrun     : one-cycle block-end / block-start-without-data pulses
// ---------------------------------------------------------------------------
interface dt_tx_framer_if #(
   parameter int ADDR_W = 6
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              commit;
   logic              fill_busy;
   logic              tx_int;
   logic              underrun;

   modport master (output wr_en, wr_addr, wr_data, commit,
                   input  fill_busy, tx_int, underrun);
   modport slave  (input  wr_en, wr_addr, wr_data, commit,
                   output fill_busy, tx_int, underrun);
endinterface

// File: rtl/dt_tx_framer.sv
// ---------------------------------------------------------------------------
// dt_tx_framer
//   Transmit side of the DT TDM link. A block of NUM_FRAMES*4 bytes is written
//   into a ping-pong fill buffer, committed, and swapped in at the next block
//   boundary; the play buffer is then serialised onto data_to_dt, one frame
//   per f0 period, one bit per two c4 periods (driven on c4 fall at even
//   counts so the far end samples it on the following c4 rise).
//   Everything runs on clk50; c4/f0 are synchronised and edge-detected here.
//
//   clk50        : system clock
//   reset_out_rg : asynchronous active-high reset
//   c4, f0       : TDM bit clock / active-low frame sync (asynchronous)
//   cpu          : byte-write / commit bus plus status pulses (slave side)
//   data_to_dt   : serial data toward DT
//   frame_idx    : frame currently being transmitted
// ---------------------------------------------------------------------------
module dt_tx_framer #(
   parameter int   NUM_FRAMES     = 16,
   parameter int   BITS_PER_FRAME = 32,
   parameter logic IDLE_BIT       = 1'b1
) (
   input  logic                          clk50,
   input  logic                          reset_out_rg,
   input  logic                          c4,
   input  logic                          f0,
   dt_tx_framer_if.slave                 cpu,
   output logic                          data_to_dt,
   output logic [$clog2(NUM_FRAMES)-1:0] frame_idx
);
   localparam int         NUM_BYTES = NUM_FRAMES * BITS_PER_FRAME / 8;
   localparam int         BUF_BITS  = NUM_FRAMES * BITS_PER_FRAME;
   localparam int         BW        = $clog2(BUF_BITS);
   localparam int         FW        = $clog2(NUM_FRAMES);
   localparam logic [9:0] LAST_CNT  = 10'(2 * BITS_PER_FRAME - 2);
   localparam logic [9:0] WIN_END   = 10'(2 * BITS_PER_FRAME);

   // c4: 2-FF synchroniser + history flop for edge detection.
   // f0 is only sampled as a level on c4 rise, so its 2-FF output is used
   // directly; it stays aligned with the c4 strobes because both paths have
   // the same synchroniser depth.
   logic [2:0] c4_sh;
   logic [1:0] f0_sh;
   logic       c4_rise, c4_fall, f0_sync;

   always_ff @(posedge clk50 or posedge reset_out_rg) begin
      if (reset_out_rg) begin
         c4_sh <= 3'b000;
         f0_sh <= 2'b11;
      end else begin
         c4_sh <= {c4_sh[1:0], c4};
         f0_sh <= {f0_sh[0], f0};
      end
   end

   assign c4_rise = c4_sh[1] & ~c4_sh[2];
   assign c4_fall = ~c4_sh[1] & c4_sh[2];
   assign f0_sync = f0_sh[1];

   // Ping-pong storage: buf_q[play_sel] is played, the other one is filled.
   logic [1:0][BUF_BITS-1:0] buf_q;
   logic                     play_sel, play_vld;
   logic [9:0]               bit_cnt;
   logic                     fill_busy_q, tx_int_q, underrun_q;

   logic          last_bit, swap, busy_after_swap, wr_ok;
   logic [BW-1:0] rd_idx, wr_idx;

   // Last data bit of a frame is being sampled by the far end right now.
   assign last_bit = c4_rise && f0_sync && (bit_cnt == LAST_CNT);
   assign swap     = last_bit && (frame_idx == FW'(NUM_FRAMES - 1));
   // A swap always leaves the fill side free: either it consumed the
   // committed buffer or there was none. A commit in the swap cycle is
   // therefore judged against this post-swap view.
   assign busy_after_swap = swap ? 1'b0 : fill_busy_q;
   assign wr_ok    = cpu.wr_en && !fill_busy_q && (int'(cpu.wr_addr) < NUM_BYTES);
   assign rd_idx   = BW'(int'(frame_idx) * BITS_PER_FRAME + int'(bit_cnt[9:1]));
   assign wr_idx   = BW'(int'(cpu.wr_addr) * 8);

   always_ff @(posedge clk50 or posedge reset_out_rg) begin
      if (reset_out_rg) begin
         buf_q       <= '0;
         play_sel    <= 1'b0;
         play_vld    <= 1'b0;
         bit_cnt     <= '0;
         frame_idx   <= '0;
         data_to_dt  <= IDLE_BIT;
         fill_busy_q <= 1'b0;
         tx_int_q    <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         tx_int_q   <= swap;
         underrun_q <= swap && !fill_busy_q;

         // Bit counter and frame advance
         if (c4_rise) begin
            if (!f0_sync) begin
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + 10'd1;
               if (last_bit)
                  frame_idx <= swap ? '0 : frame_idx + 1'b1;
            end
         end

         // Output drive; IDLE_BIT between data bits, after the window and
         // for the whole block when nothing valid is playing.
         if (c4_fall) begin
            if (play_vld && !bit_cnt[0] && (bit_cnt < WIN_END))
               data_to_dt <= buf_q[play_sel][rd_idx];
            else
               data_to_dt <= IDLE_BIT;
         end

         // Block swap
         if (swap) begin
            if (fill_busy_q) begin
               play_sel <= ~play_sel;
               play_vld <= 1'b1;
            end else begin
               play_vld <= 1'b0;
            end
         end

         // CPU side; a write in the commit cycle lands in the buffer being
         // committed because both see the pre-commit fill_busy.
         if (wr_ok)
            buf_q[~play_sel][wr_idx +: 8] <= cpu.wr_data;

         if (cpu.commit && !busy_after_swap)
            fill_busy_q <= 1'b1;
         else
            fill_busy_q <= busy_after_swap;
      end
   end

   assign cpu.fill_busy = fill_busy_q;
   assign cpu.tx_int    = tx_int_q;
   assign cpu.underrun  = underrun_q;

endmodule
